// File: rtl/servo_pwm_pkg.sv
// Shared constants, width types and the optional clamp helper for the servo PWM timebase and generator.
package servo_pwm_pkg;

  localparam int UI_W            = 12;
  localparam int N_CH            = 4;
  localparam int DEF_CLKS_PER_UI = 100;
  localparam int DEF_FRAME_UI    = 20000;
  localparam int DEF_NEUTRAL_UI  = 1500;
  localparam int DEF_MIN_UI      = 1000;
  localparam int DEF_MAX_UI      = 2000;

  typedef logic [UI_W-1:0] width_t;
  typedef width_t [N_CH-1:0] width_arr_t;

  function automatic width_t clamp_width(input width_t w, input width_t lo, input width_t hi);
    if (w < lo) return lo;
    if (w > hi) return hi;
    return w;
  endfunction

endpackage

// File: rtl/servo_pwm_div.sv
// UI prescaler and frame counter. The sof_next output marks the edge that will raise
// pulse_sof, so that update logic can act on that same edge.
module servo_pwm_div
  import servo_pwm_pkg::*;
#(
  parameter int CLKS_PER_UI = DEF_CLKS_PER_UI,
  parameter int FRAME_UI    = DEF_FRAME_UI
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tb_en,
  output logic                        pulse_ui,
  output logic                        pulse_sof,
  output logic [$clog2(FRAME_UI)-1:0] ui_cnt,
  output logic                        sof_next
);

  localparam int PRE_W = $clog2(CLKS_PER_UI);
  localparam int CNT_W = $clog2(FRAME_UI);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] ui_cnt_q, ui_cnt_d;
  logic             sof_pend_q, sof_pend_d;
  logic             pulse_ui_q, pulse_sof_q;
  logic             tick;

  // A pending SOF forces the next tick to open a new frame, whatever ui_cnt holds.
  always_comb begin
    tick       = tb_en && (pre_q == PRE_W'(CLKS_PER_UI - 1));
    sof_next   = tick && (sof_pend_q || (ui_cnt_q == CNT_W'(FRAME_UI - 1)));
    pre_d      = tick ? '0 : pre_q + PRE_W'(1);
    ui_cnt_d   = ui_cnt_q;
    sof_pend_d = sof_pend_q;
    if (!tb_en) begin
      pre_d      = '0;
      ui_cnt_d   = '0;
      sof_pend_d = 1'b1;
    end else if (sof_next) begin
      ui_cnt_d   = '0;
      sof_pend_d = 1'b0;
    end else if (tick) begin
      ui_cnt_d   = ui_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q       <= '0;
      ui_cnt_q    <= '0;
      sof_pend_q  <= 1'b1;
      pulse_ui_q  <= 1'b0;
      pulse_sof_q <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      ui_cnt_q    <= ui_cnt_d;
      sof_pend_q  <= sof_pend_d;
      pulse_ui_q  <= tick;
      pulse_sof_q <= sof_next;
    end
  end

  assign pulse_ui  = pulse_ui_q;
  assign pulse_sof = pulse_sof_q;
  assign ui_cnt    = ui_cnt_q;

endmodule

// File: rtl/servo_pwm_timebase.sv
// Servo PWM timebase: UI/SOF strobes plus frame-synchronous width update via req/ack.
// Define SERVO_TB_CLAMP_EN to clamp captured widths to [MIN_UI, MAX_UI].
module servo_pwm_timebase
  import servo_pwm_pkg::*;
#(
  parameter int CLKS_PER_UI = DEF_CLKS_PER_UI,
  parameter int FRAME_UI    = DEF_FRAME_UI,
  parameter int NEUTRAL_UI  = DEF_NEUTRAL_UI,
  parameter int MIN_UI      = DEF_MIN_UI,
  parameter int MAX_UI      = DEF_MAX_UI
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tb_en,
  input  logic [UI_W-1:0]             ch0_width_in,
  input  logic [UI_W-1:0]             ch1_width_in,
  input  logic [UI_W-1:0]             ch2_width_in,
  input  logic [UI_W-1:0]             ch3_width_in,
  input  logic                        upd_req,
  output logic                        upd_busy,
  output logic                        upd_ack,
  output logic                        pulse_ui,
  output logic                        pulse_sof,
  output logic [$clog2(FRAME_UI)-1:0] ui_cnt,
  output logic [UI_W-1:0]             ch0_pulse_width_ui,
  output logic [UI_W-1:0]             ch1_pulse_width_ui,
  output logic [UI_W-1:0]             ch2_pulse_width_ui,
  output logic [UI_W-1:0]             ch3_pulse_width_ui
);

`ifdef SERVO_TB_CLAMP_EN
  localparam bit ClampEn = 1'b1;
`else
  localparam bit ClampEn = 1'b0;
`endif

  width_arr_t width_in, staged_in;
  width_arr_t staging_q, active_q;
  logic       busy_q, ack_q, req_seen_q;
  logic       capture, apply, sof_next;

  servo_pwm_div #(
    .CLKS_PER_UI(CLKS_PER_UI),
    .FRAME_UI   (FRAME_UI)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .tb_en    (tb_en),
    .pulse_ui (pulse_ui),
    .pulse_sof(pulse_sof),
    .ui_cnt   (ui_cnt),
    .sof_next (sof_next)
  );

  // Capture needs busy clear and apply needs busy set, so a capture on the SOF edge
  // can never be applied on that same edge.
  always_comb begin
    width_in  = {ch3_width_in, ch2_width_in, ch1_width_in, ch0_width_in};
    staged_in = width_in;
    for (int i = 0; i < N_CH; i++) begin
      if (ClampEn) begin
        staged_in[i] = clamp_width(width_in[i], width_t'(MIN_UI), width_t'(MAX_UI));
      end
    end
    capture = upd_req && !busy_q && !req_seen_q;
    apply   = sof_next && busy_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      staging_q  <= {N_CH{width_t'(NEUTRAL_UI)}};
      active_q   <= {N_CH{width_t'(NEUTRAL_UI)}};
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      req_seen_q <= 1'b0;
    end else begin
      ack_q <= apply;
      if (capture) begin
        staging_q <= staged_in;
        busy_q    <= 1'b1;
      end else if (apply) begin
        active_q  <= staging_q;
        busy_q    <= 1'b0;
      end
      if (!upd_req) begin
        req_seen_q <= 1'b0;
      end else if (capture) begin
        req_seen_q <= 1'b1;
      end
    end
  end

  assign upd_busy           = busy_q;
  assign upd_ack            = ack_q;
  assign ch0_pulse_width_ui = active_q[0];
  assign ch1_pulse_width_ui = active_q[1];
  assign ch2_pulse_width_ui = active_q[2];
  assign ch3_pulse_width_ui = active_q[3];

endmodule
